// File: rtl/udp_frame_terminator_if.sv
// Bus bundle for the UDP frame terminator: decoded UDP header and payload stream in,
// header-stripped byte stream out.
interface udp_frame_terminator_if;
  logic        rx_udp_hdr_valid;
  logic        rx_udp_hdr_ready;
  logic [31:0] rx_udp_ip_dest_ip;
  logic [31:0] rx_udp_ip_source_ip;
  logic [15:0] rx_udp_source_port;
  logic [15:0] rx_udp_dest_port;
  logic [15:0] rx_udp_length;

  logic [7:0]  rx_udp_payload_axis_tdata;
  logic        rx_udp_payload_axis_tvalid;
  logic        rx_udp_payload_axis_tready;
  logic        rx_udp_payload_axis_tlast;
  logic        rx_udp_payload_axis_tuser;

  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;

  // Stack side plus downstream consumer.
  modport master (
    output rx_udp_hdr_valid, rx_udp_ip_dest_ip, rx_udp_ip_source_ip, rx_udp_source_port,
    output rx_udp_dest_port, rx_udp_length,
    output rx_udp_payload_axis_tdata, rx_udp_payload_axis_tvalid,
    output rx_udp_payload_axis_tlast, rx_udp_payload_axis_tuser,
    output m_axis_tready,
    input  rx_udp_hdr_ready, rx_udp_payload_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );

  // Terminator side.
  modport slave (
    input  rx_udp_hdr_valid, rx_udp_ip_dest_ip, rx_udp_ip_source_ip, rx_udp_source_port,
    input  rx_udp_dest_port, rx_udp_length,
    input  rx_udp_payload_axis_tdata, rx_udp_payload_axis_tvalid,
    input  rx_udp_payload_axis_tlast, rx_udp_payload_axis_tuser,
    input  m_axis_tready,
    output rx_udp_hdr_ready, rx_udp_payload_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );
endinterface

// File: rtl/udp_frame_terminator.sv
// Receive-side UDP terminator: filters frames by destination IP/port/enable, forwards
// matching payloads header-stripped, consumes the rest, and keeps frame counters.
module udp_frame_terminator #(
  parameter int unsigned COUNT_WIDTH = 16,
  parameter logic [31:0] MCAST_IP    = 32'hEF020206
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [31:0]            local_ip,
  input  logic [15:0]            listen_port,
  udp_frame_terminator_if.slave  bus,
  output logic [31:0]            m_source_ip,
  output logic [15:0]            m_source_port,
  output logic [COUNT_WIDTH-1:0] good_frame_count,
  output logic [COUNT_WIDTH-1:0] drop_frame_count,
  output logic [COUNT_WIDTH-1:0] err_frame_count
);

  typedef enum logic [1:0] {StIdle, StPass, StDrop} state_e;

  localparam logic [COUNT_WIDTH-1:0] CountOne = COUNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [15:0]            byte_cnt_q, byte_cnt_d;
  logic [15:0]            exp_len_q, exp_len_d;
  logic [31:0]            src_ip_q, src_ip_d;
  logic [15:0]            src_port_q, src_port_d;
  logic [COUNT_WIDTH-1:0] good_q, good_d;
  logic [COUNT_WIDTH-1:0] drop_q, drop_d;
  logic [COUNT_WIDTH-1:0] err_q, err_d;

  logic        len_short;
  logic        ip_ok;
  logic        hdr_match;
  logic [15:0] byte_cnt_inc;
  logic        last_bad;

  always_comb begin
    len_short    = (bus.rx_udp_length <= 16'd8);
    ip_ok        = (bus.rx_udp_ip_dest_ip == local_ip) || (bus.rx_udp_ip_dest_ip == MCAST_IP);
    hdr_match    = enable && (bus.rx_udp_dest_port == listen_port) && ip_ok && !len_short;
    byte_cnt_inc = (byte_cnt_q == 16'hFFFF) ? 16'hFFFF : byte_cnt_q + 16'd1;
    // Judged on the beat itself so the flag rides with tlast.
    last_bad     = bus.rx_udp_payload_axis_tuser || (byte_cnt_inc != exp_len_q);
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    exp_len_d  = exp_len_q;
    src_ip_d   = src_ip_q;
    src_port_d = src_port_q;
    good_d     = good_q;
    drop_d     = drop_q;
    err_d      = err_q;

    bus.rx_udp_hdr_ready           = 1'b0;
    bus.rx_udp_payload_axis_tready = 1'b0;
    bus.m_axis_tdata               = 8'h00;
    bus.m_axis_tvalid              = 1'b0;
    bus.m_axis_tlast               = 1'b0;
    bus.m_axis_tuser               = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus.rx_udp_hdr_ready = 1'b1;
        if (bus.rx_udp_hdr_valid) begin
          src_ip_d   = bus.rx_udp_ip_source_ip;
          src_port_d = bus.rx_udp_source_port;
          exp_len_d  = bus.rx_udp_length - 16'd8;
          byte_cnt_d = 16'd0;
          if (hdr_match) begin
            state_d = StPass;
          end else begin
            state_d = StDrop;
            drop_d  = drop_q + CountOne;
            if (len_short) begin
              err_d = err_q + CountOne;
            end
          end
        end
      end

      StPass: begin
        bus.rx_udp_payload_axis_tready = bus.m_axis_tready;
        bus.m_axis_tdata               = bus.rx_udp_payload_axis_tdata;
        bus.m_axis_tvalid              = bus.rx_udp_payload_axis_tvalid;
        bus.m_axis_tlast               = bus.rx_udp_payload_axis_tlast;
        bus.m_axis_tuser               = bus.rx_udp_payload_axis_tlast && last_bad;
        if (bus.rx_udp_payload_axis_tvalid && bus.m_axis_tready) begin
          byte_cnt_d = byte_cnt_inc;
          if (bus.rx_udp_payload_axis_tlast) begin
            state_d = StIdle;
            if (last_bad) begin
              err_d = err_q + CountOne;
            end else begin
              good_d = good_q + CountOne;
            end
          end
        end
      end

      StDrop: begin
        bus.rx_udp_payload_axis_tready = 1'b1;
        if (bus.rx_udp_payload_axis_tvalid && bus.rx_udp_payload_axis_tlast) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      byte_cnt_q <= 16'd0;
      exp_len_q  <= 16'd0;
      src_ip_q   <= 32'd0;
      src_port_q <= 16'd0;
      good_q     <= '0;
      drop_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      exp_len_q  <= exp_len_d;
      src_ip_q   <= src_ip_d;
      src_port_q <= src_port_d;
      good_q     <= good_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
    end
  end

  assign m_source_ip      = src_ip_q;
  assign m_source_port    = src_port_q;
  assign good_frame_count = good_q;
  assign drop_frame_count = drop_q;
  assign err_frame_count  = err_q;

endmodule

// File: tb/tb_udp_frame_terminator.sv
// Bench for udp_frame_terminator: table of directed frames, reset/idle corner cases,
// then random frames checked against a frame-level model.
module tb_udp_frame_terminator;
  localparam int unsigned CW       = 16;
  localparam logic [31:0] LOCAL_IP = 32'h0A000002;
  localparam logic [31:0] MCAST    = 32'hEF020206;
  localparam logic [31:0] OTHER_IP = 32'h0A000003;
  localparam logic [15:0] LPORT    = 16'd21007;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [31:0]   local_ip;
  logic [15:0]   listen_port;
  logic [31:0]   m_source_ip;
  logic [15:0]   m_source_port;
  logic [CW-1:0] good_frame_count, drop_frame_count, err_frame_count;

  udp_frame_terminator_if bus ();

  udp_frame_terminator #(.COUNT_WIDTH(CW), .MCAST_IP(MCAST)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .local_ip         (local_ip),
    .listen_port      (listen_port),
    .bus              (bus.slave),
    .m_source_ip      (m_source_ip),
    .m_source_port    (m_source_port),
    .good_frame_count (good_frame_count),
    .drop_frame_count (drop_frame_count),
    .err_frame_count  (err_frame_count)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] ip;
    logic [15:0] port;
    logic [15:0] len;
    int          n;
    bit          user;
    bit          en;
    int          mode;
    bit          gaps;
    bit          fwd;
    bit          tu;
    int          dg;
    int          dd;
    int          de;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int          rdy_mode = 0;
  logic [7:0]  sent_q[$];
  logic [7:0]  got_q[$];
  bit          got_last_q[$];
  bit          got_user_q[$];
  int          exp_good, exp_drop, exp_err;
  vec_t        tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Downstream ready pattern, changed just after each rising edge.
  initial begin
    bus.m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.m_axis_tready = 1'b1;
        1:       bus.m_axis_tready = ~bus.m_axis_tready;
        default: bus.m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: a beat is taken when valid&ready hold mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.m_axis_tvalid && bus.m_axis_tready) begin
        got_q.push_back(bus.m_axis_tdata);
        got_last_q.push_back(bus.m_axis_tlast);
        got_user_q.push_back(bus.m_axis_tuser);
        if (!bus.m_axis_tlast) check("tuser_mid_beat", 32'(bus.m_axis_tuser), 32'd0);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_header(input logic [31:0] ip, input logic [15:0] port,
                             input logic [15:0] len, input logic [31:0] sip,
                             input logic [15:0] sport);
    bit hs;
    int k;
    bus.rx_udp_ip_dest_ip   = ip;
    bus.rx_udp_dest_port    = port;
    bus.rx_udp_length       = len;
    bus.rx_udp_ip_source_ip = sip;
    bus.rx_udp_source_port  = sport;
    bus.rx_udp_hdr_valid    = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      hs = bus.rx_udp_hdr_ready;
      cycle();
      k++;
    end while (!hs && k < 200);
    bus.rx_udp_hdr_valid = 1'b0;
    if (!hs) check("hdr_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_byte(input logic [7:0] d, input bit last, input bit user);
    bit hs;
    int k;
    bus.rx_udp_payload_axis_tdata  = d;
    bus.rx_udp_payload_axis_tlast  = last;
    bus.rx_udp_payload_axis_tuser  = user;
    bus.rx_udp_payload_axis_tvalid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      hs = bus.rx_udp_payload_axis_tvalid && bus.rx_udp_payload_axis_tready;
      cycle();
      k++;
    end while (!hs && k < 200);
    bus.rx_udp_payload_axis_tvalid = 1'b0;
    bus.rx_udp_payload_axis_tlast  = 1'b0;
    bus.rx_udp_payload_axis_tuser  = 1'b0;
    if (!hs) check("payload_timeout", 32'd0, 32'd1);
  endtask

  // Frame-level reference: forward decision, final error flag and counter deltas.
  function automatic void model(input logic [31:0] ip, input logic [15:0] port,
                                input logic [15:0] len, input int n, input bit user,
                                input bit en, output bit fwd, output bit tu,
                                output int dg, output int dd, output int de);
    bit match;
    match = en && (port == LPORT) && (ip == LOCAL_IP || ip == MCAST) && (len > 16'd8);
    fwd = match;
    dg = 0; dd = 0; de = 0; tu = 1'b0;
    if (match) begin
      tu = user || (n != int'(len) - 8);
      if (tu) de = 1; else dg = 1;
    end else begin
      dd = 1;
      if (len <= 16'd8) de = 1;
    end
  endfunction

  task automatic run_frame(input string name, input vec_t v);
    logic [31:0] sip;
    logic [15:0] sport;
    int          nlast;
    sip   = $urandom;
    sport = 16'($urandom);
    enable   = v.en;
    rdy_mode = v.mode;
    sent_q.delete(); got_q.delete(); got_last_q.delete(); got_user_q.delete();
    send_header(v.ip, v.port, v.len, sip, sport);
    check({name, "_hdr_ready_busy"}, 32'(bus.rx_udp_hdr_ready), 32'd0);
    check({name, "_src_ip"}, m_source_ip, sip);
    check({name, "_src_port"}, 32'(m_source_port), 32'(sport));
    for (int i = 0; i < v.n; i++) begin
      logic [7:0] d;
      if (v.gaps) repeat ($urandom_range(0, 2)) cycle();
      d = 8'($urandom);
      sent_q.push_back(d);
      push_byte(d, i == v.n - 1, v.user && (i == v.n - 1));
    end
    check({name, "_hdr_ready_after_last"}, 32'(bus.rx_udp_hdr_ready), 32'd1);
    exp_good += v.dg;
    exp_drop += v.dd;
    exp_err  += v.de;
    check({name, "_good"}, 32'(good_frame_count), 32'(CW'(exp_good)));
    check({name, "_drop"}, 32'(drop_frame_count), 32'(CW'(exp_drop)));
    check({name, "_err"}, 32'(err_frame_count), 32'(CW'(exp_err)));
    if (v.fwd) begin
      check({name, "_beats"}, 32'(got_q.size()), 32'(v.n));
      if (got_q.size() == v.n) begin
        nlast = 0;
        for (int i = 0; i < v.n; i++) begin
          if (got_q[i] !== sent_q[i]) check({name, "_data"}, 32'(got_q[i]), 32'(sent_q[i]));
          nlast += int'(got_last_q[i]);
        end
        check({name, "_tlast_pos"}, 32'(got_last_q[v.n-1]) | (32'(nlast) << 4), 32'h11);
        check({name, "_tuser_last"}, 32'(got_user_q[v.n-1]), 32'(v.tu));
      end
    end else begin
      check({name, "_no_forward"}, 32'(got_q.size()), 32'd0);
    end
  endtask

  initial begin
    vec_t rv;
    rst         = 1'b1;
    enable      = 1'b1;
    local_ip    = LOCAL_IP;
    listen_port = LPORT;
    bus.rx_udp_hdr_valid           = 1'b0;
    bus.rx_udp_ip_dest_ip          = '0;
    bus.rx_udp_ip_source_ip        = '0;
    bus.rx_udp_source_port         = '0;
    bus.rx_udp_dest_port           = '0;
    bus.rx_udp_length              = '0;
    bus.rx_udp_payload_axis_tdata  = '0;
    bus.rx_udp_payload_axis_tvalid = 1'b0;
    bus.rx_udp_payload_axis_tlast  = 1'b0;
    bus.rx_udp_payload_axis_tuser  = 1'b0;
    exp_good = 0; exp_drop = 0; exp_err = 0;

    //            ip        port      len    n  usr en mode gap fwd tu dg dd de
    tbl[0]  = '{LOCAL_IP, LPORT,    16'd12, 4, 0, 1, 0, 0, 1, 0, 1, 0, 0};
    tbl[1]  = '{MCAST,    LPORT,    16'd10, 2, 0, 1, 1, 0, 1, 0, 1, 0, 0};
    tbl[2]  = '{LOCAL_IP, 16'd5000, 16'd13, 5, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    tbl[3]  = '{LOCAL_IP, LPORT,    16'd12, 6, 0, 1, 0, 0, 1, 1, 0, 0, 1};
    tbl[4]  = '{LOCAL_IP, LPORT,    16'd12, 3, 0, 1, 1, 0, 1, 1, 0, 0, 1};
    tbl[5]  = '{LOCAL_IP, LPORT,    16'd8,  1, 0, 1, 0, 0, 0, 0, 0, 1, 1};
    tbl[6]  = '{LOCAL_IP, LPORT,    16'd12, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[7]  = '{LOCAL_IP, LPORT,    16'd12, 4, 1, 1, 2, 1, 1, 1, 0, 0, 1};
    tbl[8]  = '{OTHER_IP, LPORT,    16'd12, 4, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    tbl[9]  = '{MCAST,    LPORT,    16'd9,  1, 0, 1, 2, 1, 1, 0, 1, 0, 0};
    tbl[10] = '{LOCAL_IP, 16'd7,    16'd7,  2, 0, 1, 0, 0, 0, 0, 0, 1, 1};

    repeat (3) cycle();
    rst = 1'b0;
    cycle();

    check("rst_hdr_ready", 32'(bus.rx_udp_hdr_ready), 32'd1);
    check("rst_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    check("rst_counts", {good_frame_count, drop_frame_count} | 32'(err_frame_count), 32'd0);
    check("rst_src", m_source_ip | 32'(m_source_port), 32'd0);

    // Payload offered with no header must not be taken.
    bus.rx_udp_payload_axis_tvalid = 1'b1;
    bus.rx_udp_payload_axis_tlast  = 1'b1;
    bus.rx_udp_payload_axis_tdata  = 8'hAA;
    @(negedge clk);
    check("idle_rx_tready", 32'(bus.rx_udp_payload_axis_tready), 32'd0);
    check("idle_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    cycle();
    bus.rx_udp_payload_axis_tvalid = 1'b0;
    bus.rx_udp_payload_axis_tlast  = 1'b0;

    for (int i = 0; i < 11; i++) run_frame($sformatf("vec%0d", i), tbl[i]);

    // Reset in the middle of a forwarded frame.
    enable   = 1'b1;
    rdy_mode = 0;
    cycle();
    send_header(LOCAL_IP, LPORT, 16'd12, 32'h01020304, 16'd77);
    push_byte(8'h11, 1'b0, 1'b0);
    push_byte(8'h22, 1'b0, 1'b0);
    bus.rx_udp_payload_axis_tdata  = 8'h33;
    bus.rx_udp_payload_axis_tvalid = 1'b1;
    @(negedge clk);
    check("midrst_pre_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
    rst = 1'b1;
    cycle();
    check("midrst_hdr_ready", 32'(bus.rx_udp_hdr_ready), 32'd1);
    check("midrst_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    check("midrst_counts", {good_frame_count, drop_frame_count} | 32'(err_frame_count), 32'd0);
    check("midrst_src", m_source_ip, 32'd0);
    rst = 1'b0;
    bus.rx_udp_payload_axis_tvalid = 1'b0;
    exp_good = 0; exp_drop = 0; exp_err = 0;
    cycle();

    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(0, 2))
        0:       rv.ip = LOCAL_IP;
        1:       rv.ip = MCAST;
        default: rv.ip = OTHER_IP;
      endcase
      rv.port = ($urandom_range(0, 3) != 0) ? LPORT : 16'($urandom_range(1, 2000));
      rv.len  = 16'($urandom_range(5, 20));
      rv.n    = $urandom_range(1, 14);
      rv.user = ($urandom_range(0, 7) == 0);
      rv.en   = ($urandom_range(0, 9) != 0);
      rv.mode = $urandom_range(0, 2);
      rv.gaps = 1'($urandom_range(0, 1));
      model(rv.ip, rv.port, rv.len, rv.n, rv.user, rv.en, rv.fwd, rv.tu, rv.dg, rv.dd, rv.de);
      run_frame($sformatf("rnd%0d", f), rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/udp_frame_terminator.md
Name: udp_frame_terminator

Overview:
Receive-side counterpart of the UDP payload originator. Accepts decoded UDP header plus 8-bit payload stream from the UDP/IP stack and filters by destination IP (local or multicast group), destination port and enable. Matching frames are forwarded header-stripped to the command/control path; all other frames are silently consumed. It checks the UDP length against the actual payload byte count and keeps good, drop and error frame counters.

Parameters:
COUNT_WIDTH, 16, width of each status frame counter
MCAST_IP, 32'hEF020206 (239.2.2.6), accepted multicast destination group

Ports:
clk  input  1  single clock for all logic
rst  input  1  synchronous reset, active-high
enable  input  1  0 = drop all frames
local_ip  input  32  unicast address accepted
listen_port  input  16  accepted UDP destination port
rx_udp_hdr_valid  input  1  header valid
rx_udp_hdr_ready  output  1  header ready
rx_udp_ip_dest_ip  input  32  header destination IP
rx_udp_ip_source_ip  input  32  header source IP
rx_udp_source_port  input  16  header source port
rx_udp_dest_port  input  16  header destination port
rx_udp_length  input  16  UDP length, including 8-byte header
rx_udp_payload_axis_tdata  input  8  payload byte
rx_udp_payload_axis_tvalid  input  1  payload valid
rx_udp_payload_axis_tready  output  1  payload ready
rx_udp_payload_axis_tlast  input  1  last payload byte
rx_udp_payload_axis_tuser  input  1  upstream error flag
m_axis_tdata  output  8  forwarded byte
m_axis_tvalid  output  1  forwarded valid
m_axis_tready  input  1  downstream ready
m_axis_tlast  output  1  forwarded last
m_axis_tuser  output  1  frame bad: upstream error or length mismatch
m_source_ip  output  32  latched source IP of current frame
m_source_port  output  16  latched source port of current frame
good_frame_count  output  COUNT_WIDTH  frames forwarded without error
drop_frame_count  output  COUNT_WIDTH  frames filtered out
err_frame_count  output  COUNT_WIDTH  frames forwarded or dropped with length error

Behaviour:
- States: IDLE, PASS, DROP. Reset: state=IDLE; all counters, m_source_ip/port, byte counter and expected length = 0.
- In IDLE: rx_udp_hdr_ready=1, rx payload tready=0, m_axis_tvalid=0. Header handshake latches source IP/port, expected = rx_udp_length-8, byte counter = 0.
- match = enable && rx_udp_dest_port==listen_port && (dest_ip==local_ip || dest_ip==MCAST_IP) && rx_udp_length>8.
- Header accept: match -> PASS. Otherwise -> DROP, with drop_frame_count+1. If rx_udp_length<=8, err_frame_count also +1, even when IP and port match.
- PASS is a combinational pass-through:
  - m_axis_tdata/tvalid/tlast follow rx payload; rx payload tready = m_axis_tready.
  - Byte counter +1 per transfer, saturating at 16'hFFFF.
  - m_axis_tuser is asserted only on the tlast beat: tuser = rx tuser OR (byte_counter+1 != expected); 0 on all other beats.
  - On last transfer: tuser=0 -> good+1; else err+1. State -> IDLE.
- DROP: rx payload tready=1, m_axis_tvalid=0. On last transfer -> IDLE.
- Header and payload never handshake in the same cycle. First payload byte passes at the earliest one cycle after header accept. rx_udp_hdr_ready=0 in PASS and DROP, so back-to-back headers are held off.
- m_source_ip/port stay stable from header accept until the next header accept.
- Counters wrap modulo 2^COUNT_WIDTH.
- Reset mid-frame: immediate return to IDLE. Downstream sees tvalid drop without tlast, and the remainder of the upstream frame will be misparsed. The reset owner must flush the stack as well.
- Stalls: m_axis_tready low in PASS holds rx payload; no byte may be lost or duplicated. tvalid gaps upstream pass through transparently.

Test Plan:
1. local_ip=10.0.0.2, listen_port=21007; header dest 10.0.0.2:21007, length=12, bytes 01 02 03 04 -> m_axis carries 01..04 with tlast on 04, tuser=0, good=1, m_source_* latched.
2. Header to 239.2.2.6:21007, length=10, 2 bytes, m_axis_tready toggled 1/0 every cycle -> both bytes delivered in order, no duplicates, good=2.
3. Header port 5000, length=13, 5 bytes -> m_axis_tvalid stays 0, all 5 consumed, drop=1, hdr_ready returns 1 one cycle after last.
4. Matching header length=12 with 6 payload bytes -> 6 bytes forwarded, tuser=1 on the 6th only, err=1, good unchanged; repeat with 3 bytes -> tuser=1 on 3rd.
5. Matching header length=8 -> dropped, drop=1 and err=1; enable=0 with matching header -> drop+1 only.
6. Reset asserted after 2 of 4 forwarded bytes -> next cycle state IDLE, hdr_ready=1, m_axis_tvalid=0, counters=0.
